// File: rtl/cla_sub_serial.sv
// cla_sub_serial -- chunk-serial subtractor computing d = a - b - b_in.
//
// Operands are latched on a valid/ready handshake; one NBIT-wide chunk of
// the difference is produced per clock using a carry-lookahead adder on
// a + ~b + carry. After the last chunk a finalize cycle derives the
// borrow-out, then the result is held until the consumer accepts it.
//
// Parameters:
//   NBIT      chunk width in bits (processed per cycle)
//   NCHUNK    chunks per operand; operand width W = NBIT*NCHUNK
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   a, b, b_in valid
//   in_ready   block accepts operands (IDLE only)
//   a          minuend, W bits
//   b          subtrahend, W bits
//   b_in       borrow in
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts result
//   d          difference a - b - b_in modulo 2^W
//   b_out      borrow out, 1 iff a < b + b_in (unsigned)
//   ovf        (only with CLA_SUB_OVF_EN defined) signed overflow flag
//
// Optional feature macro: CLA_SUB_OVF_EN adds the ovf output and its logic.

module cla_sub_serial #(
    parameter int NBIT   = 4,
    parameter int NCHUNK = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NBIT*NCHUNK-1:0] a,
    input  logic [NBIT*NCHUNK-1:0] b,
    input  logic                   b_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NBIT*NCHUNK-1:0] d,
    output logic                   b_out
`ifdef CLA_SUB_OVF_EN
    ,
    output logic                   ovf
`endif
);

    localparam int W    = NBIT * NCHUNK;
    localparam int IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state;
    logic [W-1:0]      a_r;
    logic [W-1:0]      b_r;
    logic              bin_r;
    logic [IDXW-1:0]   idx;
    logic              carry_r;
    logic              last_r;

    // Current chunk datapath
    logic [NBIT-1:0]   a_chunk;
    logic [NBIT-1:0]   nb_chunk;
    logic [NBIT-1:0]   g;
    logic [NBIT-1:0]   p;
    logic [NBIT-1:0]   sum_chunk;
    logic [NBIT:0]     c;
    logic              cin;
    logic              cout;
    logic              ck;
    logic              pp;

    // Each carry c[k] is formed directly from generate/propagate terms and
    // cin (two-level lookahead form), never from the previous carry bit.
    always_comb begin
        a_chunk  = a_r[idx*NBIT +: NBIT];
        nb_chunk = ~b_r[idx*NBIT +: NBIT];
        cin      = (idx == '0) ? ~bin_r : carry_r;
        g        = a_chunk & nb_chunk;
        p        = a_chunk ^ nb_chunk;
        c        = '0;
        ck       = 1'b0;
        pp       = 1'b1;
        c[0]     = cin;
        for (int unsigned k = 1; k <= NBIT; k++) begin
            ck = 1'b0;
            pp = 1'b1;
            for (int unsigned j = k; j > 0; j--) begin
                ck = ck | (pp & g[j-1]);
                pp = pp & p[j-1];
            end
            c[k] = ck | (pp & cin);
        end
        sum_chunk = p ^ c[NBIT-1:0];
        cout      = c[NBIT];
    end

    // last_r marks that every chunk has been written; the extra BUSY cycle
    // it creates turns the registered final carry into b_out, giving the
    // NCHUNK+1 cycle accept-to-valid latency while keeping idx in range.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            d         <= '0;
            b_out     <= 1'b0;
            idx       <= '0;
            carry_r   <= 1'b0;
            last_r    <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            bin_r     <= 1'b0;
`ifdef CLA_SUB_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= b;
                        bin_r    <= b_in;
                        idx      <= '0;
                        last_r   <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (!last_r) begin
                        d[idx*NBIT +: NBIT] <= sum_chunk;
                        carry_r             <= cout;
                        if (idx == LAST_IDX) begin
                            last_r <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        b_out     <= ~carry_r;
`ifdef CLA_SUB_OVF_EN
                        ovf       <= (a_r[W-1] != b_r[W-1]) && (d[W-1] != a_r[W-1]);
`endif
                        out_valid <= 1'b1;
                        idx       <= '0;
                        last_r    <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_sub_serial.sv
// tb_cla_sub_serial -- self-checking bench for cla_sub_serial (NBIT=4,
// NCHUNK=8). Expected results are computed by a wide-arithmetic model or
// taken from constant tables and queued when operands are accepted; they
// are popped and compared when the DUT presents out_valid.
// Define CLA_SUB_OVF_EN to also check the ovf output.

module tb_cla_sub_serial;

    localparam int NBIT   = 4;
    localparam int NCHUNK = 8;
    localparam int W      = NBIT * NCHUNK;
    localparam int LAT    = NCHUNK + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         b_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] d;
    logic         b_out;
    logic         ovf;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    cla_sub_serial #(
        .NBIT   (NBIT),
        .NCHUNK (NCHUNK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .b_out     (b_out)
`ifdef CLA_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

`ifndef CLA_SUB_OVF_EN
    assign ovf = 1'b0;
`endif

    // Reference model: unsigned borrow from a W+1 bit subtraction, signed
    // overflow from a sign-extended subtraction whose top two bits disagree.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic bi);
        exp_t         m;
        logic [W:0]   u;
        logic [W:0]   s;
        u    = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bi};
        s    = {av[W-1], av} - {bv[W-1], bv} - {{W{1'b0}}, bi};
        m.d  = u[W-1:0];
        m.bo = u[W];
        m.ov = s[W] ^ s[W-1];
        return m;
    endfunction

    // Stimulus: present operands from a negedge, wait for in_ready, return at
    // the negedge after the accepting edge and queue the expected result.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        bit ok;
        ok       = 1'b0;
        a        = av;
        b        = bv;
        b_in     = bi;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!ok) begin
            $display("FAIL send_timeout: in_ready=%0b required 1 within 50 cycles", in_ready);
            in_valid = 1'b0;
        end else begin
            passed++;
            @(negedge clk);
            in_valid = 1'b0;
            sb.push_back(model(av, bv, bi));
            // scramble the inputs; the latched operands must be used
            a    = $urandom;
            b    = $urandom;
            b_in = 1'($urandom);
        end
    endtask

    // Wait for out_valid; cyc is the number of clock edges after the accepting edge.
    task automatic wait_out(output int cyc);
        bit ok;
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        total++;
        if (!ok) $display("FAIL out_valid_timeout: out_valid=%0b required 1 within 40 cycles", out_valid);
        else passed++;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        b_in      = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        total++;
        if ({in_ready, out_valid, b_out, ovf, d} !== {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
            $display("FAIL reset_state: in_ready=%0b out_valid=%0b b_out=%0b ovf=%0b d=%h required 1 0 0 0 %h",
                     in_ready, out_valid, b_out, ovf, d, {W{1'b0}});
        end else passed++;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [3] = '{32'h0000_0005, 32'h0000_0000, 32'h0000_0010};
        logic [W-1:0] tb [3] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_000F};
        logic         tbi[3] = '{1'b0, 1'b0, 1'b1};
        logic [W-1:0] td [3] = '{32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000};
        logic         tbo[3] = '{1'b0, 1'b1, 1'b0};
        int           cyc;
        for (int i = 0; i < 3; i++) begin
            send(ta[i], tb[i], tbi[i]);
            wait_out(cyc);
            if (sb.size() > 0) void'(sb.pop_front());
            total++;
            if (cyc !== LAT) $display("FAIL directed%0d_latency: got %0d cycles required %0d", i, cyc, LAT);
            else passed++;
            total++;
            if (d !== td[i]) $display("FAIL directed%0d_d: got %h required %h", i, d, td[i]);
            else passed++;
            total++;
            if (b_out !== tbo[i]) $display("FAIL directed%0d_b_out: got %0b required %0b", i, b_out, tbo[i]);
            else passed++;
            consume();
        end
    endtask

    task automatic test_hold();
        exp_t e;
        int   cyc;
        send(32'hA5A5_1234, 32'h5A5A_4321, 1'b1);
        wait_out(cyc);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({out_valid, in_ready, b_out, d} !== {1'b1, 1'b0, e.bo, e.d}) begin
                $display("FAIL hold_cycle%0d: out_valid=%0b in_ready=%0b b_out=%0b d=%h required 1 0 %0b %h",
                         i, out_valid, in_ready, b_out, d, e.bo, e.d);
            end else passed++;
            // new operands offered while DONE must be ignored
            in_valid = 1'b1;
            a        = $urandom;
            b        = $urandom;
            @(negedge clk);
        end
        out_ready = 1'b1;
        total++;
        if (in_ready !== 1'b0) $display("FAIL hold_release_in_ready: got %0b required 0", in_ready);
        else passed++;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        total++;
        if ({out_valid, in_ready} !== 2'b01) $display("FAIL hold_idle: out_valid,in_ready=%b required 01", {out_valid, in_ready});
        else passed++;
        @(negedge clk);
        total++;
        if ({out_valid, in_ready} !== 2'b01) $display("FAIL hold_no_accept: out_valid,in_ready=%b required 01", {out_valid, in_ready});
        else passed++;
    endtask

    task automatic test_abort();
        bit seen;
        send(32'h1234_5678, 32'h0FED_CBA9, 1'b0);
        if (sb.size() > 0) void'(sb.pop_back());
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({out_valid, in_ready, b_out, d} !== {1'b0, 1'b1, 1'b0, {W{1'b0}}}) begin
            $display("FAIL abort_state: out_valid=%0b in_ready=%0b b_out=%0b d=%h required 0 1 0 %h",
                     out_valid, in_ready, b_out, d, {W{1'b0}});
        end else passed++;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) $display("FAIL abort_no_valid: out_valid seen=%0b required 0", seen);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic         bi;
        exp_t         e;
        int           cyc;
        for (int i = 0; i < 10; i++) begin
            case (i)
                0:       begin av = 32'hFFFF_FFFF; bv = 32'h0000_0000; bi = 1'b1; end
                1:       begin av = 32'h0000_0000; bv = 32'h0000_0000; bi = 1'b1; end
                2:       begin av = 32'h8765_4321; bv = 32'h8765_4321; bi = 1'b0; end
                3:       begin av = 32'h7FFF_FFFF; bv = 32'hFFFF_FFFF; bi = 1'b0; end
                default: begin av = $urandom; bv = $urandom; bi = 1'($urandom); end
            endcase
            send(av, bv, bi);
            wait_out(cyc);
            e = sb.pop_front();
            total++;
            if ({cyc == LAT, b_out, d} !== {1'b1, e.bo, e.d}) begin
                $display("FAIL b2b%0d: cyc=%0d b_out=%0b d=%h required cyc=%0d b_out=%0b d=%h",
                         i, cyc, b_out, d, LAT, e.bo, e.d);
            end else passed++;
`ifdef CLA_SUB_OVF_EN
            total++;
            if (ovf !== e.ov) $display("FAIL b2b%0d_ovf: got %0b required %0b", i, ovf, e.ov);
            else passed++;
`endif
            consume();
        end
    endtask

`ifdef CLA_SUB_OVF_EN
    task automatic test_ovf();
        int cyc;
        send(32'h8000_0000, 32'h0000_0001, 1'b0);
        wait_out(cyc);
        if (sb.size() > 0) void'(sb.pop_front());
        total++;
        if ({d, ovf, b_out} !== {32'h7FFF_FFFF, 1'b1, 1'b0}) begin
            $display("FAIL ovf_min_minus_one: d=%h ovf=%0b b_out=%0b required 7fffffff 1 0", d, ovf, b_out);
        end else passed++;
        consume();
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_hold();
        test_abort();
        test_back_to_back();
`ifdef CLA_SUB_OVF_EN
        test_ovf();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
